// File: rtl/csr_access_unit.sv
// -----------------------------------------------------------------------------
// csr_access_unit
// Initiator side of the CSR file interface. Runs one Zicsr instruction per
// request (CSRRW/CSRRS/CSRRC and the immediate forms). It reads the CSR,
// computes the new value, issues the write strobe and returns the old value
// for rd.
//
// Sequence (all outputs registered):
//   IDLE -start-> READ -> (illegal ? DONE : WRITE) -> DONE -> IDLE
//   start sampled at edge 0 -> csr_we in cycle 2, done in cycle 3 (legal),
//   or done+illegal in cycle 2 (illegal).
//
// Ports
//   clk, resetn          clock, synchronous active-low reset
//   start                request strobe, accepted only while idle (busy==0)
//   funct3               Zicsr funct3 (001 RW, 010 RS, 011 RC, 101/110/111 imm)
//   csr_sel              target CSR address
//   rs1_val              rs1 value (register forms)
//   rs1_idx              rs1 index, or zimm for the immediate forms
//   rd_idx               destination register index
//   priv                 current privilege (only used with CSR_PRIV_CHECK_EN)
//   csr_addr/csr_wdata   address and write data to the CSR file
//   csr_we               one-cycle CSR write strobe
//   csr_rdata            combinational read data for csr_addr
//   rd_wdata/rd_we       old CSR value and one-cycle GPR write strobe
//   done/illegal         completion pulse, illegal-instruction flag with done
//   busy                 operation in flight
//
// Build option
//   CSR_PRIV_CHECK_EN    when defined, an access with priv < csr_sel[9:8] is
//                        also illegal. Undefined: priv is ignored.
// -----------------------------------------------------------------------------
module csr_access_unit #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] csr_sel,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [4:0]        rs1_idx,
    input  logic [4:0]        rd_idx,
    input  logic [1:0]        priv,
    output logic [ADDR_W-1:0] csr_addr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              csr_we,
    input  logic [XLEN-1:0]   csr_rdata,
    output logic [XLEN-1:0]   rd_wdata,
    output logic              rd_we,
    output logic              done,
    output logic              illegal,
    output logic              busy
);

    localparam int unsigned REG_IDX_W = 5;

    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                 state_q;
    logic [2:0]             f3_q;
    logic [ADDR_W-1:0]      sel_q;
    logic [XLEN-1:0]        op_q;
    logic [XLEN-1:0]        old_q;
    logic [REG_IDX_W-1:0]   rs1_idx_q;
    logic [REG_IDX_W-1:0]   rd_idx_q;

    logic                   f3_bad;
    logic                   wr_en;
    logic                   ro_space;
    logic                   priv_bad;
    logic                   is_illegal;
    logic [XLEN-1:0]        new_val;

    // Legality and new-value evaluation from the latched request and the
    // read data presented during READ.
    always_comb begin
        f3_bad     = (f3_q == 3'b000) || (f3_q == 3'b100);
        // set/clear with x0 or zimm==0 is a pure read
        wr_en      = (f3_q == F3_RW) || (f3_q == F3_RWI) ||
                     (rs1_idx_q != REG_IDX_W'(0));
        ro_space   = (sel_q[11:10] == 2'b11);
`ifdef CSR_PRIV_CHECK_EN
        priv_bad   = (priv < sel_q[9:8]);
`else
        priv_bad   = 1'b0;
`endif
        is_illegal = f3_bad || (wr_en && ro_space) || priv_bad;

        new_val = op_q;
        case (f3_q)
            F3_RS, F3_RSI: new_val = csr_rdata | op_q;
            F3_RC, F3_RCI: new_val = csr_rdata & ~op_q;
            default:       new_val = op_q;
        endcase
    end

`ifndef CSR_PRIV_CHECK_EN
    // priv has no function in this build
    logic unused_priv;
    assign unused_priv = ^priv;
`endif

    // Sequencer with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            f3_q      <= 3'b000;
            sel_q     <= '0;
            op_q      <= '0;
            old_q     <= '0;
            rs1_idx_q <= '0;
            rd_idx_q  <= '0;
            csr_addr  <= '0;
            csr_wdata <= '0;
            csr_we    <= 1'b0;
            rd_wdata  <= '0;
            rd_we     <= 1'b0;
            done      <= 1'b0;
            illegal   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            csr_we  <= 1'b0;
            rd_we   <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        f3_q      <= funct3;
                        sel_q     <= csr_sel;
                        // immediate forms carry a zero-extended zimm
                        op_q      <= funct3[2] ? XLEN'(rs1_idx) : rs1_val;
                        rs1_idx_q <= rs1_idx;
                        rd_idx_q  <= rd_idx;
                        csr_addr  <= csr_sel;
                        busy      <= 1'b1;
                        state_q   <= S_READ;
                    end
                end

                S_READ: begin
                    old_q <= csr_rdata;
                    if (is_illegal) begin
                        done     <= 1'b1;
                        illegal  <= 1'b1;
                        rd_wdata <= csr_rdata;
                        state_q  <= S_DONE;
                    end else begin
                        csr_wdata <= new_val;
                        csr_we    <= wr_en;
                        state_q   <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    done     <= 1'b1;
                    rd_we    <= (rd_idx_q != REG_IDX_W'(0));
                    rd_wdata <= old_q;
                    state_q  <= S_DONE;
                end

                S_DONE: begin
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// -----------------------------------------------------------------------------
// tb_csr_access_unit
// Directed bench for csr_access_unit. The bench plays the CSR file (a memory
// read combinationally at csr_addr, written on csr_we). A cycle-indexed table
// of expected outputs is filled from the Zicsr rules whenever a request is
// accepted, and one process compares the DUT against it every cycle. Each
// directed vector also carries hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_csr_access_unit;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned NCYC   = 1024;

    logic              clk = 1'b0;
    logic              resetn;
    logic              start;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] csr_sel;
    logic [XLEN-1:0]   rs1_val;
    logic [4:0]        rs1_idx;
    logic [4:0]        rd_idx;
    logic [1:0]        priv;
    logic [ADDR_W-1:0] csr_addr;
    logic [XLEN-1:0]   csr_wdata;
    logic              csr_we;
    logic [XLEN-1:0]   csr_rdata;
    logic [XLEN-1:0]   rd_wdata;
    logic              rd_we;
    logic              done;
    logic              illegal;
    logic              busy;

    csr_access_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .funct3    (funct3),
        .csr_sel   (csr_sel),
        .rs1_val   (rs1_val),
        .rs1_idx   (rs1_idx),
        .rd_idx    (rd_idx),
        .priv      (priv),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_we    (csr_we),
        .csr_rdata (csr_rdata),
        .rd_wdata  (rd_wdata),
        .rd_we     (rd_we),
        .done      (done),
        .illegal   (illegal),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // CSR file stand-in
    logic [XLEN-1:0]   csr_mem [0:4095];
    logic              pre_en;
    logic [ADDR_W-1:0] pre_addr;
    logic [XLEN-1:0]   pre_val;

    assign csr_rdata = csr_mem[csr_addr];

    always @(posedge clk) begin
        if (csr_we)      csr_mem[csr_addr] <= csr_wdata;
        else if (pre_en) csr_mem[pre_addr] <= pre_val;
    end

    // cycle counter: period k is the interval after the k-th rising edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // expected-output table
    typedef struct {
        logic              busy;
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [XLEN-1:0]   wdata;
        logic              done;
        logic              ill;
        logic              rd_we;
        logic [XLEN-1:0]   rd_wdata;
    } exp_t;

    exp_t exp_q [0:NCYC-1];
    int   idle_from = 0;
    logic chk_on = 1'b0;

    task automatic clear_exp(input int p);
        if (p >= 0 && p < int'(NCYC)) begin
            exp_q[p].busy     = 1'b0;
            exp_q[p].addr     = '0;
            exp_q[p].we       = 1'b0;
            exp_q[p].wdata    = '0;
            exp_q[p].done     = 1'b0;
            exp_q[p].ill      = 1'b0;
            exp_q[p].rd_we    = 1'b0;
            exp_q[p].rd_wdata = '0;
        end
    endtask

    // Request accepted at edge a: derive the whole transaction from the rules.
    task automatic model_accept(input int a);
        logic [XLEN-1:0] old_v, op_v, nv;
        logic            wr, ill;
        int              kind;
        logic [1:0]      space;
        logic [1:0]      req_priv;
        old_v = csr_mem[csr_sel];
        case (funct3)
            3'b001, 3'b101: kind = 1;
            3'b010, 3'b110: kind = 2;
            3'b011, 3'b111: kind = 3;
            default:        kind = 0;
        endcase
        op_v     = funct3[2] ? {27'b0, rs1_idx} : rs1_val;
        wr       = (kind == 1) || (rs1_idx != 5'd0);
        space    = csr_sel[11:10];
        req_priv = csr_sel[9:8];
        ill      = (kind == 0) || (wr && space == 2'b11);
`ifdef CSR_PRIV_CHECK_EN
        if (priv < req_priv) ill = 1'b1;
`else
        if (req_priv == 2'b00 && priv == 2'b00) ill = ill; // priv has no effect
`endif
        if (kind == 2)      nv = old_v | op_v;
        else if (kind == 3) nv = old_v & ~op_v;
        else                nv = op_v;

        if (a + 3 >= int'(NCYC)) return;
        exp_q[a].busy   = 1'b1;
        exp_q[a].addr   = csr_sel;
        exp_q[a+1].busy = 1'b1;
        exp_q[a+1].addr = csr_sel;
        if (ill) begin
            exp_q[a+1].done     = 1'b1;
            exp_q[a+1].ill      = 1'b1;
            exp_q[a+1].rd_wdata = old_v;
            idle_from = a + 3;
        end else begin
            exp_q[a+1].we       = wr;
            exp_q[a+1].wdata    = nv;
            exp_q[a+2].busy     = 1'b1;
            exp_q[a+2].addr     = csr_sel;
            exp_q[a+2].done     = 1'b1;
            exp_q[a+2].rd_we    = (rd_idx != 5'd0);
            exp_q[a+2].rd_wdata = old_v;
            idle_from = a + 4;
        end
    endtask

    // One clock of stimulus: inputs change at the falling edge.
    task automatic step(input logic st);
        start = st;
        if (!resetn) begin
            for (int k = 1; k <= 5; k++) clear_exp(cyc + k);
            idle_from = cyc + 2;
        end else if (st && (cyc + 1) >= idle_from) begin
            model_accept(cyc + 1);
        end
        @(negedge clk);
    endtask

    // per-cycle comparison against the expected table
    always @(negedge clk) begin
        if (chk_on && cyc < int'(NCYC)) begin
            chk("busy",    {31'b0, busy},    {31'b0, exp_q[cyc].busy});
            chk("csr_we",  {31'b0, csr_we},  {31'b0, exp_q[cyc].we});
            chk("done",    {31'b0, done},    {31'b0, exp_q[cyc].done});
            chk("illegal", {31'b0, illegal}, {31'b0, exp_q[cyc].ill});
            chk("rd_we",   {31'b0, rd_we},   {31'b0, exp_q[cyc].rd_we});
            if (exp_q[cyc].busy) chk("csr_addr", {20'b0, csr_addr}, {20'b0, exp_q[cyc].addr});
            if (exp_q[cyc].we)   chk("csr_wdata", csr_wdata, exp_q[cyc].wdata);
            if (exp_q[cyc].done) chk("rd_wdata", rd_wdata, exp_q[cyc].rd_wdata);
        end
    end

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] v);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_val  = v;
        step(1'b0);
        pre_en   = 1'b0;
    endtask

    task automatic set_req(input logic [2:0] f3, input logic [ADDR_W-1:0] sel,
                           input logic [XLEN-1:0] rv, input logic [4:0] ri,
                           input logic [4:0] rdi, input logic [1:0] pr);
        funct3  = f3;
        csr_sel = sel;
        rs1_val = rv;
        rs1_idx = ri;
        rd_idx  = rdi;
        priv    = pr;
    endtask

    // Directed vector with literal expectations at each stage.
    task automatic do_op(input string nm, input logic [2:0] f3, input logic [ADDR_W-1:0] sel,
                         input logic [XLEN-1:0] rv, input logic [4:0] ri, input logic [4:0] rdi,
                         input logic [1:0] pr, input logic [XLEN-1:0] init,
                         input logic e_ill, input logic e_we, input logic [XLEN-1:0] e_wdata,
                         input logic e_rdwe, input logic [XLEN-1:0] e_old);
        preload(sel, init);
        set_req(f3, sel, rv, ri, rdi, pr);
        step(1'b1);                                   // cycle 1: READ
        chk({nm, ".c1.busy"}, {31'b0, busy}, 32'd1);
        chk({nm, ".c1.addr"}, {20'b0, csr_addr}, {20'b0, sel});
        step(1'b0);                                   // cycle 2
        if (e_ill) begin
            chk({nm, ".c2.done"},    {31'b0, done},    32'd1);
            chk({nm, ".c2.illegal"}, {31'b0, illegal}, 32'd1);
            chk({nm, ".c2.csr_we"},  {31'b0, csr_we},  32'd0);
            chk({nm, ".c2.rd_we"},   {31'b0, rd_we},   32'd0);
            step(1'b0);
            chk({nm, ".c3.done"},    {31'b0, done},    32'd0);
        end else begin
            chk({nm, ".c2.csr_we"}, {31'b0, csr_we}, {31'b0, e_we});
            chk({nm, ".c2.done"},   {31'b0, done},   32'd0);
            if (e_we) chk({nm, ".c2.wdata"}, csr_wdata, e_wdata);
            step(1'b0);                               // cycle 3: DONE
            chk({nm, ".c3.done"},     {31'b0, done},    32'd1);
            chk({nm, ".c3.illegal"},  {31'b0, illegal}, 32'd0);
            chk({nm, ".c3.rd_we"},    {31'b0, rd_we},   {31'b0, e_rdwe});
            chk({nm, ".c3.rd_wdata"}, rd_wdata, e_old);
            chk({nm, ".c3.csr_we"},   {31'b0, csr_we},  32'd0);
            step(1'b0);
        end
        chk({nm, ".end.busy"}, {31'b0, busy}, 32'd0);
        step(1'b0);
    endtask

    int n_done;
    int n_we;

    initial begin
        for (int i = 0; i < int'(NCYC); i++) clear_exp(i);
        resetn = 1'b0;
        start  = 1'b0;
        pre_en = 1'b0;
        pre_addr = '0;
        pre_val  = '0;
        set_req(3'b000, 12'h000, 32'h0, 5'd0, 5'd0, 2'd0);

        @(negedge clk);
        step(1'b0);
        step(1'b0);
        chk("rst.busy",    {31'b0, busy},    32'd0);
        chk("rst.done",    {31'b0, done},    32'd0);
        chk("rst.csr_we",  {31'b0, csr_we},  32'd0);
        chk("rst.rd_we",   {31'b0, rd_we},   32'd0);
        chk("rst.illegal", {31'b0, illegal}, 32'd0);
        chk("rst.addr",    {20'b0, csr_addr}, 32'd0);
        chk_on = 1'b1;
        resetn = 1'b1;
        step(1'b0);

        //      name      f3      sel      rs1_val       idx  rd  pr  init          ill we  wdata         rdwe old
        do_op("rw",      3'b001, 12'h340, 32'hDEADBEEF, 5'd6, 5'd5, 2'd3, 32'h12345678, 0, 1, 32'hDEADBEEF, 1, 32'h12345678);
        chk("rw.mem", csr_mem[12'h340], 32'hDEADBEEF);
        do_op("rs_x0",   3'b010, 12'h304, 32'hFFFF0000, 5'd0, 5'd3, 2'd3, 32'h000000A5, 0, 0, 32'h0,        1, 32'h000000A5);
        chk("rs_x0.mem", csr_mem[12'h304], 32'h000000A5);
        do_op("rci",     3'b111, 12'h300, 32'h0,        5'd8, 5'd1, 2'd3, 32'h0000000F, 0, 1, 32'h00000007, 1, 32'h0000000F);
        do_op("rsi",     3'b110, 12'h300, 32'h0,        5'h10,5'd0, 2'd3, 32'h0000000F, 0, 1, 32'h0000001F, 0, 32'h0000000F);
        do_op("rc_reg",  3'b011, 12'h341, 32'h0000FF00, 5'd4, 5'd9, 2'd3, 32'hFFFFFFFF, 0, 1, 32'hFFFF00FF, 1, 32'hFFFFFFFF);
        do_op("rwi_z0",  3'b101, 12'h305, 32'hFFFFFFFF, 5'd0, 5'd2, 2'd3, 32'h00001234, 0, 1, 32'h00000000, 1, 32'h00001234);
        do_op("ro_rw",   3'b001, 12'hF11, 32'h11111111, 5'd7, 5'd7, 2'd3, 32'h00001234, 1, 0, 32'h0,        0, 32'h0);
        chk("ro_rw.mem", csr_mem[12'hF11], 32'h00001234);
        do_op("f3_100",  3'b100, 12'h340, 32'h1,        5'd1, 5'd5, 2'd3, 32'h0,        1, 0, 32'h0,        0, 32'h0);
        do_op("f3_000",  3'b000, 12'h340, 32'h1,        5'd1, 5'd5, 2'd3, 32'h0,        1, 0, 32'h0,        0, 32'h0);
        do_op("ro_read", 3'b010, 12'hF14, 32'h0,        5'd0, 5'd4, 2'd3, 32'h00000002, 0, 0, 32'h0,        1, 32'h00000002);
        do_op("ro_rs",   3'b010, 12'hC00, 32'h4,        5'd2, 5'd4, 2'd3, 32'h0,        1, 0, 32'h0,        0, 32'h0);
`ifdef CSR_PRIV_CHECK_EN
        do_op("priv_lo", 3'b010, 12'h300, 32'h8,        5'd1, 5'd4, 2'd0, 32'h0,        1, 0, 32'h0,        0, 32'h0);
        do_op("priv_hi", 3'b010, 12'h300, 32'h8,        5'd1, 5'd4, 2'd3, 32'h0,        0, 1, 32'h00000008, 1, 32'h0);
`else
        do_op("priv_ign",3'b010, 12'h300, 32'h8,        5'd1, 5'd4, 2'd0, 32'h0,        0, 1, 32'h00000008, 1, 32'h0);
`endif

        // start held through the whole operation: only one transaction
        preload(12'h340, 32'h0);
        set_req(3'b011, 12'h340, 32'h1, 5'd3, 5'd5, 2'd3);
        pre_en = 1'b0;
        preload(12'h340, 32'h000000FF);
        n_done = 0;
        n_we   = 0;
        for (int i = 0; i < 8; i++) begin
            step(i < 4);
            if (done)   n_done++;
            if (csr_we) n_we++;
        end
        chk("hold.n_done", n_done, 32'd1);
        chk("hold.n_we",   n_we,   32'd1);
        chk("hold.mem",    csr_mem[12'h340], 32'h000000FE);

        // reset during WRITE aborts the operation
        preload(12'h341, 32'h0000AAAA);
        set_req(3'b001, 12'h341, 32'h5555, 5'd6, 5'd8, 2'd3);
        step(1'b1);
        step(1'b0);
        chk("abort.c2.csr_we", {31'b0, csr_we}, 32'd1);
        resetn = 1'b0;
        step(1'b0);
        resetn = 1'b1;
        n_done = 0;
        n_we   = 0;
        for (int i = 0; i < 6; i++) begin
            if (done)   n_done++;
            if (csr_we) n_we++;
            step(1'b0);
        end
        chk("abort.n_done", n_done, 32'd0);
        chk("abort.n_we",   n_we,   32'd0);
        chk("abort.busy",   {31'b0, busy}, 32'd0);
        chk("abort.addr",   {20'b0, csr_addr}, 32'd0);

        // unit still works after the abort
        do_op("post_rst",3'b001, 12'h342, 32'hCAFEF00D, 5'd1, 5'd10, 2'd3, 32'h00000001, 0, 1, 32'hCAFEF00D, 1, 32'h00000001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
